prm_edge_mask_engine: RTL and testbench

PRM_EDGE_MASK_ENGINE -- requirements
Module: prm_edge_mask_engine

---
 rtl/prm_edge_mask_engine_pkg.sv | 24 ++
 rtl/prm_edge_mask_engine_cube_match.sv | 19 +
 rtl/prm_edge_mask_engine.sv | 159 +++++++++++++++
 tb/tb_prm_edge_mask_engine.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prm_edge_mask_engine_pkg.sv
// Shared types for the PRM edge mask engine: cube record, FSM states and
// the parameter legality check used at elaboration.
package prm_edge_mask_engine_pkg;

  localparam int unsigned KEY_W_MAX = 32;

  typedef struct packed {
    logic [KEY_W_MAX-1:0] care;
    logic [KEY_W_MAX-1:0] val;
    logic                 en;
  } cube_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic bit lanes_divide_cubes(input int unsigned n_cube,
                                            input int unsigned lanes);
    return (lanes != 0) && ((n_cube % lanes) == 0);
  endfunction

endpackage

// File: rtl/prm_edge_mask_engine_cube_match.sv
// Single product-term test: a cube matches when enabled and every cared
// bit of the key equals the cube literal.
module prm_cube_match
  import prm_edge_mask_engine_pkg::*;
#(
  parameter int KEY_W = 15
) (
  input  logic [KEY_W-1:0] key,
  input  cube_t            cube,
  output logic             match
);

  logic [KEY_W_MAX-1:0] key_ext;

  // Cube fields arrive zero-extended, so the unused upper care bits never mask in.
  assign key_ext = KEY_W_MAX'(key);
  assign match   = cube.en && (((key_ext ^ cube.val) & cube.care) == '0);

endmodule

// File: rtl/prm_edge_mask_engine.sv
// Multi-obstacle cube-cover tester: evaluates LANES cubes per obstacle per
// cycle against a captured key and reports which obstacles were hit.
module prm_edge_mask_engine
  import prm_edge_mask_engine_pkg::*;
#(
  parameter int KEY_W  = 15,
  parameter int N_OBS  = 4,
  parameter int N_CUBE = 64,
  parameter int LANES  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_we,
  output logic                      cfg_ready,
  input  logic [$clog2(N_OBS)-1:0]  cfg_obs,
  input  logic [$clog2(N_CUBE)-1:0] cfg_idx,
  input  logic [KEY_W-1:0]          cfg_care,
  input  logic [KEY_W-1:0]          cfg_val,
  input  logic                      cfg_en,
  input  logic                      q_valid,
  output logic                      q_ready,
  input  logic [KEY_W-1:0]          q_key,
  input  logic [N_OBS-1:0]          q_obs_en,
  output logic                      r_valid,
  input  logic                      r_ready,
  output logic [N_OBS-1:0]          r_mask,
  output logic                      r_any
);

  localparam int N_BLK = N_CUBE / LANES;
  localparam int BLK_W = (N_BLK > 1) ? $clog2(N_BLK) : 1;
  localparam int IDX_W = $clog2(N_CUBE);
  localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(N_BLK - 1);

  if (!lanes_divide_cubes(N_CUBE, LANES) || (KEY_W > KEY_W_MAX)) begin : g_bad_cfg
    $error("prm_edge_mask_engine: N_CUBE must be a multiple of LANES and KEY_W <= KEY_W_MAX");
  end

  logic [KEY_W-1:0]  care_q [N_OBS][N_CUBE];
  logic [KEY_W-1:0]  val_q  [N_OBS][N_CUBE];
  logic [N_CUBE-1:0] en_q   [N_OBS];

  state_t            state;
  logic [BLK_W-1:0]  blk;
  logic [KEY_W-1:0]  key_q;
  logic [N_OBS-1:0]  obs_en_q;
  logic [N_OBS-1:0]  hit_q;

  logic              wr_hit;
  cube_t             lane_cube  [N_OBS][LANES];
  logic [LANES-1:0]  lane_match [N_OBS];
  logic [N_OBS-1:0]  blk_hit;
  logic [N_OBS-1:0]  hit_next;
  logic [N_OBS-1:0]  result;
  logic              all_hit;

  assign wr_hit = cfg_we && cfg_ready && (int'(cfg_obs) < N_OBS);

  always_ff @(posedge clk) begin
    if (wr_hit) begin
      care_q[cfg_obs][cfg_idx] <= cfg_care;
      val_q[cfg_obs][cfg_idx]  <= cfg_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned o = 0; o < N_OBS; o++) en_q[o] <= '0;
    end else if (wr_hit) begin
      en_q[cfg_obs][cfg_idx] <= cfg_en;
    end
  end

  always_comb begin
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned o = 0; o < N_OBS; o++) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        idx                  = IDX_W'(blk * LANES + l);
        lane_cube[o][l]      = '0;
        lane_cube[o][l].care = KEY_W_MAX'(care_q[o][idx]);
        lane_cube[o][l].val  = KEY_W_MAX'(val_q[o][idx]);
        lane_cube[o][l].en   = en_q[o][idx];
      end
    end
  end

  for (genvar o = 0; o < N_OBS; o++) begin : g_obs
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      prm_cube_match #(.KEY_W(KEY_W)) u_match (
        .key   (key_q),
        .cube  (lane_cube[o][l]),
        .match (lane_match[o][l])
      );
    end
  end

  always_comb begin
    blk_hit = '0;
    for (int unsigned o = 0; o < N_OBS; o++) blk_hit[o] = |lane_match[o];
    hit_next = hit_q | blk_hit;
    result   = hit_next & obs_en_q;
    // An empty obstacle set is trivially "all hit", giving the one-cycle pass.
    all_hit  = (result == obs_en_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      q_ready   <= 1'b0;
      cfg_ready <= 1'b0;
      r_valid   <= 1'b0;
      r_mask    <= '0;
      r_any     <= 1'b0;
      hit_q     <= '0;
      blk       <= '0;
      key_q     <= '0;
      obs_en_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          q_ready   <= 1'b1;
          cfg_ready <= 1'b1;
          if (q_valid && q_ready) begin
            key_q     <= q_key;
            obs_en_q  <= q_obs_en;
            hit_q     <= '0;
            blk       <= '0;
            q_ready   <= 1'b0;
            cfg_ready <= 1'b0;
            state     <= EVAL;
          end
        end
        EVAL: begin
          hit_q <= hit_next;
          blk   <= blk + 1'b1;
          if (all_hit || (blk == LAST_BLK)) begin
            r_valid <= 1'b1;
            r_mask  <= result;
            r_any   <= |result;
            state   <= DONE;
          end
        end
        DONE: begin
          if (r_ready) begin
            r_valid   <= 1'b0;
            r_mask    <= '0;
            r_any     <= 1'b0;
            q_ready   <= 1'b1;
            cfg_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prm_edge_mask_engine.sv
// Bench for prm_edge_mask_engine: directed vector table, hand-written
// corner sequences and random tables checked against a sum-of-products model.
module tb_prm_edge_mask_engine;

  localparam int KEY_W  = 15;
  localparam int N_OBS  = 4;
  localparam int N_CUBE = 64;
  localparam int LANES  = 8;
  localparam int N_BLK  = N_CUBE / LANES;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_we = 1'b0;
  logic             cfg_ready;
  logic [1:0]       cfg_obs = '0;
  logic [5:0]       cfg_idx = '0;
  logic [KEY_W-1:0] cfg_care = '0;
  logic [KEY_W-1:0] cfg_val = '0;
  logic             cfg_en = 1'b0;
  logic             q_valid = 1'b0;
  logic             q_ready;
  logic [KEY_W-1:0] q_key = '0;
  logic [N_OBS-1:0] q_obs_en = '0;
  logic             r_valid;
  logic             r_ready = 1'b0;
  logic [N_OBS-1:0] r_mask;
  logic             r_any;

  int checks = 0;
  int failures = 0;

  logic [KEY_W-1:0] m_care [N_OBS][N_CUBE];
  logic [KEY_W-1:0] m_val  [N_OBS][N_CUBE];
  bit               m_en   [N_OBS][N_CUBE];

  prm_edge_mask_engine #(.KEY_W(KEY_W), .N_OBS(N_OBS), .N_CUBE(N_CUBE), .LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_obs(cfg_obs), .cfg_idx(cfg_idx),
    .cfg_care(cfg_care), .cfg_val(cfg_val), .cfg_en(cfg_en),
    .q_valid(q_valid), .q_ready(q_ready), .q_key(q_key), .q_obs_en(q_obs_en),
    .r_valid(r_valid), .r_ready(r_ready), .r_mask(r_mask), .r_any(r_any)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int o = 0; o < N_OBS; o++)
      for (int k = 0; k < N_CUBE; k++) begin
        m_care[o][k] = '0;
        m_val[o][k]  = '0;
        m_en[o][k]   = 1'b0;
      end
  endtask

  task automatic model_write(input int o, input int k, input logic [KEY_W-1:0] care,
                             input logic [KEY_W-1:0] val, input bit en);
    m_care[o][k] = care;
    m_val[o][k]  = val;
    m_en[o][k]   = en;
  endtask

  // Expected mask from the SOP definition; latency from the block holding
  // the first matching cube of each requested obstacle.
  task automatic model_eval(input logic [KEY_W-1:0] key, input logic [N_OBS-1:0] q_en,
                            output logic [N_OBS-1:0] mask, output int lat);
    int  fb;
    int  worst;
    bit  all;
    mask  = '0;
    worst = 0;
    all   = 1'b1;
    for (int o = 0; o < N_OBS; o++) begin
      fb = -1;
      for (int k = 0; k < N_CUBE; k++)
        if (fb < 0 && m_en[o][k] && (((key ^ m_val[o][k]) & m_care[o][k]) == '0))
          fb = k / LANES;
      if (q_en[o]) begin
        if (fb < 0) all = 1'b0;
        else begin
          mask[o] = 1'b1;
          if (fb > worst) worst = fb;
        end
      end
    end
    lat = all ? worst + 2 : N_BLK + 1;
  endtask

  task automatic cfg_write(input int o, input int k, input logic [KEY_W-1:0] care,
                           input logic [KEY_W-1:0] val, input bit en);
    int n;
    n = 0;
    while (!cfg_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("cfg_ready_wait", 32'(cfg_ready), 32'd1);
    cfg_we = 1'b1; cfg_obs = 2'(o); cfg_idx = 6'(k);
    cfg_care = care; cfg_val = val; cfg_en = en;
    model_write(o, k, care, val, en);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic run_query(input logic [KEY_W-1:0] key, input logic [N_OBS-1:0] q_en,
                           input bit wr, input int o, input int k,
                           input logic [KEY_W-1:0] care, input logic [KEY_W-1:0] val,
                           input bit en,
                           output logic [N_OBS-1:0] mask, output logic any, output int lat);
    int n;
    n = 0;
    while (!q_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("q_ready_wait", 32'(q_ready), 32'd1);
    q_valid = 1'b1; q_key = key; q_obs_en = q_en;
    if (wr) begin
      cfg_we = 1'b1; cfg_obs = 2'(o); cfg_idx = 6'(k);
      cfg_care = care; cfg_val = val; cfg_en = en;
      model_write(o, k, care, val, en);
    end
    @(posedge clk);
    @(negedge clk);
    q_valid = 1'b0;
    cfg_we  = 1'b0;
    lat = 1;
    while (!r_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    mask = r_mask;
    any  = r_any;
    r_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0;
  endtask

  typedef struct {
    string            name;
    bit               wr;
    int               obs;
    int               idx;
    logic [KEY_W-1:0] care;
    logic [KEY_W-1:0] val;
    bit               en;
    logic [KEY_W-1:0] key;
    logic [N_OBS-1:0] q_en;
    logic [N_OBS-1:0] exp_mask;
    int               exp_lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [N_OBS-1:0] mask;
    logic [N_OBS-1:0] exp_mask;
    logic             any;
    int               lat;
    int               exp_lat;
    int               seen;

    vecs.push_back('{"hit_obs1_all",   0, 0, 0,  '0,       '0,       0, 15'h0ABC, 4'hF, 4'b0010, 9});
    vecs.push_back('{"miss_abd",       0, 0, 0,  '0,       '0,       0, 15'h0ABD, 4'hF, 4'b0000, 9});
    vecs.push_back('{"hit_obs1_only",  0, 0, 0,  '0,       '0,       0, 15'h0ABC, 4'h2, 4'b0010, 9});
    vecs.push_back('{"no_obs",         0, 0, 0,  '0,       '0,       0, 15'h0ABC, 4'h0, 4'b0000, 2});
    vecs.push_back('{"obs1_masked",    0, 0, 0,  '0,       '0,       0, 15'h0ABC, 4'hD, 4'b0000, 9});
    vecs.push_back('{"care0_concur",   1, 0, 0,  15'h0000, 15'h0000, 1, 15'h5555, 4'h1, 4'b0001, 2});
    vecs.push_back('{"obs01_hit",      0, 0, 0,  '0,       '0,       0, 15'h0ABC, 4'h3, 4'b0011, 9});
    vecs.push_back('{"obs0_only",      0, 0, 0,  '0,       '0,       0, 15'h7FFF, 4'h3, 4'b0001, 9});
    vecs.push_back('{"obs2_concur",    1, 2, 5,  15'h7FFF, 15'h1111, 1, 15'h1111, 4'h4, 4'b0100, 2});
    vecs.push_back('{"obs02_early",    0, 0, 0,  '0,       '0,       0, 15'h1111, 4'h5, 4'b0101, 2});
    vecs.push_back('{"obs012_full",    0, 0, 0,  '0,       '0,       0, 15'h1111, 4'h7, 4'b0101, 9});
    vecs.push_back('{"obs2_disable",   1, 2, 5,  15'h7FFF, 15'h1111, 0, 15'h1111, 4'h4, 4'b0000, 9});
    vecs.push_back('{"all_obs",        0, 0, 0,  '0,       '0,       0, 15'h0ABC, 4'hF, 4'b0011, 9});
    vecs.push_back('{"partial_care",   1, 3, 20, 15'h00F0, 15'h0030, 1, 15'h7F3F, 4'h8, 4'b1000, 4});
    vecs.push_back('{"partial_miss",   0, 0, 0,  '0,       '0,       0, 15'h7F4F, 4'h8, 4'b0000, 9});
    vecs.push_back('{"blk2_exit",      0, 0, 0,  '0,       '0,       0, 15'h7F3F, 4'h9, 4'b1001, 4});

    // Reset behaviour
    model_clear();
    #12;
    check("rst_q_ready",   32'(q_ready),   32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    check("rst_r_valid",   32'(r_valid),   32'd0);
    check("rst_r_mask",    32'(r_mask),    32'd0);
    check("rst_r_any",     32'(r_any),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_q_ready",   32'(q_ready),   32'd1);
    check("post_rst_cfg_ready", 32'(cfg_ready), 32'd1);

    run_query(15'h1234, 4'hF, 0, 0, 0, '0, '0, 0, mask, any, lat);
    check("empty_mask", 32'(mask), 32'd0);
    check("empty_any",  32'(any),  32'd0);
    check("empty_lat",  32'(lat),  32'd9);

    cfg_write(1, 63, 15'h7FFF, 15'h0ABC, 1'b1);

    foreach (vecs[i]) begin
      run_query(vecs[i].key, vecs[i].q_en, vecs[i].wr, vecs[i].obs, vecs[i].idx,
                vecs[i].care, vecs[i].val, vecs[i].en, mask, any, lat);
      check({vecs[i].name, "_mask"}, 32'(mask), 32'(vecs[i].exp_mask));
      check({vecs[i].name, "_any"},  32'(any),  32'(|vecs[i].exp_mask));
      check({vecs[i].name, "_lat"},  32'(lat),  32'(vecs[i].exp_lat));
    end

    // DONE hold with back-pressure; config writes and new queries must be ignored
    @(negedge clk);
    q_valid = 1'b1; q_key = 15'h0ABC; q_obs_en = 4'h3;
    @(posedge clk);
    @(negedge clk);
    q_valid = 1'b0;
    seen = 0;
    while (!r_valid && seen < 40) begin
      @(negedge clk);
      seen++;
    end
    check("hold_r_valid_rise", 32'(r_valid), 32'd1);
    cfg_we = 1'b1; cfg_obs = 2'd0; cfg_idx = 6'd0; cfg_care = 15'h7FFF; cfg_val = '0; cfg_en = 1'b0;
    q_valid = 1'b1; q_key = 15'h0000; q_obs_en = 4'hF;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold_r_mask",  32'(r_mask),  32'h3);
      check("hold_r_valid", 32'(r_valid), 32'd1);
      check("hold_q_ready", 32'(q_ready), 32'd0);
    end
    cfg_we = 1'b0; q_valid = 1'b0;
    r_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0;
    check("hold_release_r_valid", 32'(r_valid), 32'd0);
    run_query(15'h5555, 4'h1, 0, 0, 0, '0, '0, 0, mask, any, lat);
    check("readback_mask", 32'(mask), 32'h1);
    check("readback_lat",  32'(lat),  32'd2);

    // Reset during EVAL cycle 3 discards the query and the table
    q_valid = 1'b1; q_key = 15'h2222; q_obs_en = 4'hF;
    @(posedge clk);
    @(negedge clk);
    q_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    #1;
    check("midrst_r_valid",   32'(r_valid),   32'd0);
    check("midrst_q_ready",   32'(q_ready),   32'd0);
    check("midrst_cfg_ready", 32'(cfg_ready), 32'd0);
    check("midrst_r_mask",    32'(r_mask),    32'd0);
    seen = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c == 2) rst_n = 1'b1;
      if (r_valid) seen++;
      if (c == 3) check("midrst_q_ready_back", 32'(q_ready), 32'd1);
    end
    check("midrst_no_r_valid", 32'(seen), 32'd0);
    run_query(15'h0ABC, 4'hF, 0, 0, 0, '0, '0, 0, mask, any, lat);
    check("cleared_mask", 32'(mask), 32'd0);
    check("cleared_lat",  32'(lat),  32'd9);
    run_query(15'h5555, 4'h1, 0, 0, 0, '0, '0, 0, mask, any, lat);
    check("cleared_care0_mask", 32'(mask), 32'd0);

    // Random tables and keys against the model
    for (int it = 0; it < 60; it++) begin
      int               nw;
      int               ro;
      int               rk;
      bit               wr;
      logic [KEY_W-1:0] rcare;
      logic [KEY_W-1:0] rval;
      logic [KEY_W-1:0] key;
      logic [N_OBS-1:0] qen;
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) begin
        rcare = 15'($urandom & $urandom & $urandom);
        cfg_write($urandom_range(0, N_OBS-1), $urandom_range(0, N_CUBE-1), rcare,
                  15'($urandom), ($urandom % 4) != 0);
      end
      ro = $urandom_range(0, N_OBS-1);
      rk = $urandom_range(0, N_CUBE-1);
      if ($urandom % 2 == 0) key = m_val[ro][rk] ^ (15'($urandom) & ~m_care[ro][rk]);
      else key = 15'($urandom);
      qen   = 4'($urandom);
      wr    = ($urandom % 4) == 0;
      rcare = 15'($urandom & $urandom & $urandom);
      rval  = key ^ (15'($urandom) & ~rcare);
      run_query(key, qen, wr, $urandom_range(0, N_OBS-1), $urandom_range(0, N_CUBE-1),
                rcare, rval, 1'b1, mask, any, lat);
      model_eval(key, qen, exp_mask, exp_lat);
      check("rand_mask", 32'(mask), 32'(exp_mask));
      check("rand_any",  32'(any),  32'(|exp_mask));
      check("rand_lat",  32'(lat),  32'(exp_lat));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
